// File: rtl/apb_master_ctrl.sv
// Single-outstanding APB master: valid/ready command in, one-cycle response out.
// Define APB_MASTER_PSLVERR_EN to add the PSLVERR input and report slave errors.
module apb_master_ctrl #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PRDATA
`ifdef APB_MASTER_PSLVERR_EN
    ,
    input  logic              PSLVERR
`endif
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          timeout_hit;
    logic          slv_err;

    assign cmd_ready   = (state == IDLE);
    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt == CNT_MAX);

`ifdef APB_MASTER_PSLVERR_EN
    assign slv_err = PSLVERR;
`else
    assign slv_err = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            cnt       <= '0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PADDR   <= cmd_addr;
                        PWRITE  <= cmd_write;
                        PWDATA  <= cmd_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    cnt     <= '0;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over a timeout landing in the same cycle
                    if (PREADY) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= slv_err;
                        rsp_rdata <= (!PWRITE && !slv_err) ? PRDATA : '0;
                        state     <= IDLE;
                    end else if (timeout_hit) begin
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
Single-outstanding APB master that turns a simple valid/ready command stream (from CPU-side glue or a sequencer) into compliant APB SETUP/ACCESS transfers toward peripheral slaves such as the APB PWM block. It returns a one-cycle response with read data and an error flag. A configurable timeout aborts transfers whose slave never asserts PREADY.

Parameters:
ADDR_W, 32, width of cmd_addr / PADDR
DATA_W, 32, width of wdata/rdata/PWDATA/PRDATA
TIMEOUT_CYCLES, 16, consecutive ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESETn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  transfer address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  transfer failed (timeout, or PSLVERR with macro); valid with rsp_valid
rsp_rdata  out  DATA_W  read data; valid with rsp_valid
PADDR  out  ADDR_W  APB address
PWRITE  out  1  APB direction
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWDATA  out  DATA_W  APB write data
PREADY  in  1  slave ready
PRDATA  in  DATA_W  slave read data

Behaviour:
- Clock PCLK; reset PRESETn is asynchronous, active-low.
- Reset state:
  - FSM in IDLE.
  - PSEL, PENABLE, PWRITE, rsp_valid, rsp_err = 0.
  - PADDR, PWDATA, rsp_rdata = 0.
  - Timeout counter = 0.
  - cmd_ready = 1, decoded combinationally from state == IDLE.
- All APB and rsp_* outputs are registered.
- FSM states and transitions:
  - IDLE -> SETUP on the handshake. On that edge, latch PADDR, PWRITE, PWDATA, and set PSEL = 1, PENABLE = 0.
  - SETUP -> ACCESS unconditionally after 1 cycle. Set PENABLE = 1 and clear the counter.
  - ACCESS, PREADY = 1: complete. On that edge go to IDLE and set PSEL = PENABLE = 0, rsp_valid = 1.
    - rsp_err = 0.
    - rsp_rdata = PRDATA for reads; 0 for writes.
  - ACCESS, PREADY = 0: stay in ACCESS and increment the counter.
    - When the counter reaches TIMEOUT_CYCLES-1 with PREADY still 0 (TIMEOUT_CYCLES > 0), abort: go to IDLE with PSEL = PENABLE = 0, rsp_valid = 1, rsp_err = 1, rsp_rdata = 0.
- Latency: handshake at edge N gives PSEL at N+1 and PENABLE at N+2. Completion with zero wait states gives rsp_valid at N+3. Each wait state adds 1 cycle.
- rsp_valid is high for exactly one cycle. There is no back-pressure on the response.
- Back-to-back commands: cmd_ready is high in the cycle rsp_valid is high. A new handshake there starts SETUP immediately, giving a 3-cycle-per-transfer throughput. PSEL drops for one cycle between transfers.
- Bus stability:
  - PADDR, PWRITE, PWDATA are stable from SETUP through completion.
  - After completion they hold their last value; PWRITE is cleared only by reset.
- Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1 bit. It never wraps; it saturates at abort.
- A PREADY assertion in the same cycle the counter hits its limit counts as success. PREADY outside ACCESS is ignored.
- Command inputs are ignored while cmd_ready = 0.
- Reset mid-transfer: the transfer is abandoned, all outputs return to reset values asynchronously, and no response is emitted.

Optional Feature:
APB_MASTER_PSLVERR_EN
- Defined: adds input port PSLVERR (1 bit). It is sampled on the completing ACCESS edge, where rsp_err = PSLVERR and rsp_rdata = 0 if PSLVERR = 1.
- Undefined: the port is absent and rsp_err reflects only timeout.

Test Plan:
- Write addr 1 data 120, slave PREADY = 1 -> PSEL at N+1, PENABLE at N+2, rsp_valid at N+3, rsp_err = 0, PADDR = 1, PWDATA = 120.
- Three back-to-back writes (1:120, 2:5, 0:1), cmd_valid held high -> cmd_ready pulses every 3 cycles, rsp_valid 3 times with rsp_err = 0, PSEL low exactly 1 cycle between transfers.
- Read addr 0x10, PREADY low 3 ACCESS cycles then high with PRDATA = 0xA5A5_0F0F -> ACCESS lasts 4 cycles, rsp_rdata = 0xA5A5_0F0F, rsp_err = 0.
- TIMEOUT_CYCLES = 16, PREADY held 0 -> abort after 16 ACCESS cycles, rsp_valid = 1, rsp_err = 1, PSEL = PENABLE = 0 next cycle, cmd_ready = 1.
- PRESETn pulsed low during ACCESS -> PSEL/PENABLE drop immediately, no rsp_valid, next command runs normally.
- With APB_MASTER_PSLVERR_EN: write completes with PREADY = 1, PSLVERR = 1 -> rsp_err = 1. Without it -> rsp_err = 0.
